// File: rtl/move_arbiter_if.sv
// move_arbiter_if: move requests in, registered board/turn/illegal status out.
interface move_arbiter_if #(parameter int SIZE = 3, parameter int CNT_W = 4);
  localparam int CELLS = SIZE * SIZE;
  localparam int MC_W = $clog2(CELLS + 1);
  logic clear;
  logic plyr_valid;
  logic [CELLS-1:0] plyr;
  logic comp_valid;
  logic [CELLS-1:0] comp;
  logic [2*CELLS-1:0] board;
  logic turn;
  logic full;
  logic [MC_W-1:0] move_cnt;
  logic illegal;
  logic [1:0] illegal_code;
  logic [CNT_W-1:0] illegal_cnt;
  modport slave(input clear, plyr_valid, plyr, comp_valid, comp,
                output board, turn, full, move_cnt, illegal, illegal_code, illegal_cnt);
  modport master(output clear, plyr_valid, plyr, comp_valid, comp,
                 input board, turn, full, move_cnt, illegal, illegal_code, illegal_cnt);
endinterface

// File: rtl/move_arbiter.sv
// move_arbiter: turn-ordered tic-tac-toe move arbiter and sole owner of the board register.
module move_arbiter #(parameter int SIZE = 3, parameter int CNT_W = 4) (
  input logic clock,
  input logic reset,
  move_arbiter_if.slave bus
);
  localparam int CELLS = SIZE * SIZE;
  localparam int MC_W = $clog2(CELLS + 1);
  typedef enum logic [1:0] {P_TURN, C_TURN, FULL} state_t;
  state_t state, state_d;
  logic [2*CELLS-1:0] board, board_d;
  logic [MC_W-1:0] move_cnt, move_cnt_d;
  logic illegal, illegal_d;
  logic [1:0] code, code_d;
  logic [CNT_W-1:0] icnt, icnt_d;
  logic [CELLS-1:0] vec, occ;
  logic own, other, onehot, legal;
  always_comb begin
    occ = '0;
    for (int i = 0; i < CELLS; i++) occ[i] = |board[2*i+:2];
  end
  // In FULL no side owns the turn, so any strobe counts as out of turn
  assign own = state == P_TURN ? bus.plyr_valid : state == C_TURN ? bus.comp_valid : 1'b0;
  assign other = state == P_TURN ? bus.comp_valid : state == C_TURN ? bus.plyr_valid :
                 bus.plyr_valid | bus.comp_valid;
  assign vec = state == C_TURN ? bus.comp : bus.plyr;
  assign onehot = vec != '0 && (vec & (vec - 1'b1)) == '0;
  assign legal = own && onehot && (vec & occ) == '0;
  always_comb begin
    state_d = state;
    board_d = board;
    move_cnt_d = move_cnt;
    illegal_d = other | (own & ~legal);
    code_d = code;
    icnt_d = icnt;
    if (legal) begin
      for (int i = 0; i < CELLS; i++)
        if (vec[i]) board_d[2*i+:2] = state == P_TURN ? 2'b01 : 2'b10;
      move_cnt_d = move_cnt + 1'b1;
      state_d = move_cnt_d == MC_W'(CELLS) ? FULL : state == P_TURN ? C_TURN : P_TURN;
    end
    if (illegal_d) begin
      code_d = other ? 2'b11 : !onehot ? 2'b10 : 2'b01;
      icnt_d = &icnt ? icnt : icnt + 1'b1;
    end
    if (bus.clear) begin
      state_d = P_TURN;
      board_d = '0;
      move_cnt_d = '0;
      illegal_d = 1'b0;
      code_d = 2'b00;
      icnt_d = '0;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= P_TURN;
      board <= '0;
      move_cnt <= '0;
      illegal <= 1'b0;
      code <= 2'b00;
      icnt <= '0;
    end else begin
      state <= state_d;
      board <= board_d;
      move_cnt <= move_cnt_d;
      illegal <= illegal_d;
      code <= code_d;
      icnt <= icnt_d;
    end
  assign bus.board = board;
  assign bus.turn = state == C_TURN;
  assign bus.full = state == FULL;
  assign bus.move_cnt = move_cnt;
  assign bus.illegal = illegal;
  assign bus.illegal_code = code;
  assign bus.illegal_cnt = icnt;
endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: directed vector table on a 3x3 board plus CNT_W=2 and SIZE=4 corner sequences.
module tb_move_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  move_arbiter_if #(.SIZE(3), .CNT_W(4)) b3();
  move_arbiter_if #(.SIZE(3), .CNT_W(2)) b2();
  move_arbiter_if #(.SIZE(4), .CNT_W(4)) b4();
  move_arbiter #(.SIZE(3), .CNT_W(4)) u3(.clock(clk), .reset(rst), .bus(b3));
  move_arbiter #(.SIZE(3), .CNT_W(2)) u2(.clock(clk), .reset(rst), .bus(b2));
  move_arbiter #(.SIZE(4), .CNT_W(4)) u4(.clock(clk), .reset(rst), .bus(b4));
  typedef struct {
    logic clr, pv;
    logic [8:0] p;
    logic cv;
    logic [8:0] c;
    logic [17:0] bd;
    logic t, f;
    logic [3:0] mc;
    logic il;
    logic [1:0] cd;
    logic [3:0] ic;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(int clr, int pv, int p, int cv, int c, int bd,
                              int t, int f, int mc, int il, int cd, int ic);
    vec_t r;
    r.clr = clr[0]; r.pv = pv[0]; r.p = p[8:0]; r.cv = cv[0]; r.c = c[8:0];
    r.bd = bd[17:0]; r.t = t[0]; r.f = f[0]; r.mc = mc[3:0]; r.il = il[0];
    r.cd = cd[1:0]; r.ic = ic[3:0];
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  initial begin
    logic [31:0] exp4;
    {b3.clear, b3.plyr_valid, b3.plyr, b3.comp_valid, b3.comp} = '0;
    {b2.clear, b2.plyr_valid, b2.plyr, b2.comp_valid, b2.comp} = '0;
    {b4.clear, b4.plyr_valid, b4.plyr, b4.comp_valid, b4.comp} = '0;
    //        clr pv p      cv c      board     t f mc il cd ic
    tbl.push_back(mk(0, 1, 'h010, 0, 'h000, 'h00100, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h010, 'h00100, 1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h003, 'h00100, 1, 0, 1, 1, 2, 2));
    tbl.push_back(mk(0, 0, 'h000, 0, 'h000, 'h00100, 1, 0, 1, 0, 2, 2));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h001, 'h00102, 0, 0, 2, 0, 2, 2));
    tbl.push_back(mk(0, 1, 'h000, 0, 'h000, 'h00102, 0, 0, 2, 1, 2, 3));
    tbl.push_back(mk(0, 1, 'h010, 0, 'h000, 'h00102, 0, 0, 2, 1, 1, 4));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h100, 'h00102, 0, 0, 2, 1, 3, 5));
    tbl.push_back(mk(1, 0, 'h000, 0, 'h000, 'h00000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h001, 1, 'h100, 'h00001, 1, 0, 1, 1, 3, 1));
    tbl.push_back(mk(1, 0, 'h000, 1, 'h002, 'h00000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h001, 0, 'h000, 'h00001, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h002, 'h00009, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h004, 0, 'h000, 'h00019, 1, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h008, 'h00099, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h010, 0, 'h000, 'h00199, 1, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h020, 'h00999, 0, 0, 6, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h040, 0, 'h000, 'h01999, 1, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h080, 'h09999, 0, 0, 8, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h100, 0, 'h000, 'h19999, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h001, 0, 'h000, 'h19999, 0, 1, 9, 1, 3, 1));
    tbl.push_back(mk(0, 0, 'h000, 1, 'h002, 'h19999, 0, 1, 9, 1, 3, 2));
    tbl.push_back(mk(1, 0, 'h000, 0, 'h000, 'h00000, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset board", 64'(b3.board), 0);
    chk("reset turn/full", {b3.turn, b3.full}, 0);
    chk("reset move_cnt", 64'(b3.move_cnt), 0);
    chk("reset illegal", {b3.illegal, b3.illegal_code, b3.illegal_cnt}, 0);
    rst = 1'b0;
    foreach (tbl[k]) begin
      b3.clear = tbl[k].clr;
      b3.plyr_valid = tbl[k].pv;
      b3.plyr = tbl[k].p;
      b3.comp_valid = tbl[k].cv;
      b3.comp = tbl[k].c;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d board", k), 64'(b3.board), 64'(tbl[k].bd));
      chk($sformatf("v%0d turn", k), 64'(b3.turn), 64'(tbl[k].t));
      chk($sformatf("v%0d full", k), 64'(b3.full), 64'(tbl[k].f));
      chk($sformatf("v%0d move_cnt", k), 64'(b3.move_cnt), 64'(tbl[k].mc));
      chk($sformatf("v%0d illegal", k), 64'(b3.illegal), 64'(tbl[k].il));
      chk($sformatf("v%0d code", k), 64'(b3.illegal_code), 64'(tbl[k].cd));
      chk($sformatf("v%0d illegal_cnt", k), 64'(b3.illegal_cnt), 64'(tbl[k].ic));
    end
    {b3.clear, b3.plyr_valid, b3.comp_valid} = '0;
    b2.comp_valid = 1'b1;
    b2.comp = 9'h001;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d cnt", k), 64'(b2.illegal_cnt), k < 3 ? 64'(k + 1) : 64'd3);
      chk($sformatf("sat%0d pulse", k), {b2.illegal, b2.illegal_code}, 3'b111);
    end
    b2.comp_valid = 1'b0;
    b2.plyr_valid = 1'b1;
    b2.plyr = 9'h001;
    @(posedge clk);
    #1;
    chk("pre-areset board", 64'(b2.board), 1);
    chk("pre-areset turn", {b2.turn, b2.move_cnt, b2.illegal}, {1'b1, 4'd1, 1'b0});
    b2.plyr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("areset board", 64'(b2.board), 0);
    chk("areset state", {b2.turn, b2.full, b2.move_cnt}, 0);
    chk("areset illegal", {b2.illegal, b2.illegal_code, b2.illegal_cnt}, 0);
    #1 rst = 1'b0;
    exp4 = '0;
    for (int i = 0; i < 16; i++) begin
      b4.plyr_valid = i % 2 == 0;
      b4.comp_valid = i % 2 == 1;
      b4.plyr = 16'(1) << i;
      b4.comp = 16'(1) << i;
      exp4[2*i+:2] = i % 2 == 0 ? 2'b01 : 2'b10;
      @(posedge clk);
      #1;
      chk($sformatf("s4 m%0d board", i), 64'(b4.board), 64'(exp4));
      chk($sformatf("s4 m%0d cnt", i), 64'(b4.move_cnt), 64'(i + 1));
      chk($sformatf("s4 m%0d flags", i), {b4.full, b4.turn, b4.illegal},
          i == 15 ? 3'b100 : {1'b0, i % 2 == 0, 1'b0});
    end
    chk("s4 final board", 64'(b4.board), 64'h99999999);
    b4.comp_valid = 1'b0;
    b4.plyr_valid = 1'b1;
    b4.plyr = 16'h0001;
    b4.clear = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("s4 clear board", 64'(b4.board), 0);
      chk("s4 clear state", {b4.full, b4.turn, b4.move_cnt}, 0);
      chk("s4 clear illegal", {b4.illegal, b4.illegal_cnt}, 0);
    end
    {b4.clear, b4.plyr_valid} = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/move_arbiter.md
# move_arbiter

Registered, parametrised board-state arbiter for the tic-tac-toe game. It accepts one-hot move requests from the player and computer paths and enforces turn order. It rejects moves to occupied cells, malformed (non-one-hot) moves and moves made out of turn. Legal moves are committed into an internal board register. The block sits between the move encoders and the win/draw logic and is the single owner of board state.

## Interface
- SIZE, 3, board side length; CELLS = SIZE*SIZE (localparam), cell i is row i/SIZE, column i%SIZE
- CNT_W, 4, width of the saturating illegal-move counter
- MC_W (localparam) = $clog2(CELLS+1), width of move_cnt

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous new-game request; priority over every move input
- plyr_valid  in  1  player move strobe, sampled each cycle
- plyr  in  CELLS  player move, must be one-hot
- comp_valid  in  1  computer move strobe
- comp  in  CELLS  computer move, must be one-hot
- board  out  2*CELLS  cell i at bits [2i+1:2i]: 00 empty, 01 player, 10 computer (11 never driven)
- turn  out  1  0 = player to move, 1 = computer to move
- full  out  1  high while all CELLS cells are occupied
- move_cnt  out  MC_W  number of committed moves
- illegal  out  1  one-cycle pulse for a rejected move
- illegal_code  out  2  cause of the last rejection, held until next rejection or clear: 01 occupied, 10 not one-hot, 11 out of turn/board full
- illegal_cnt  out  CNT_W  rejected-move count, saturates at 2^CNT_W-1

## Operation
- State machine: P_TURN, C_TURN, FULL. It is the single source of turn (turn = state==C_TURN) and full (state==FULL).
- Reset or clear gives:
  - state P_TURN, board all 00, move_cnt 0
  - illegal 0, illegal_code 00, illegal_cnt 0
- Each cycle without clear, at most one move is evaluated: plyr in P_TURN, comp in C_TURN.
- Rejection checks, highest priority first:
  - 11: strobe from the non-turn side, or any strobe in FULL
  - 10: turn-side vector has zero or more than one bit set
  - 01: selected cell already non-00
- Legal move:
  - write 01 (player) or 10 (computer) into the cell
  - increment move_cnt
  - go to the other turn state, or to FULL if move_cnt reaches CELLS
- Illegal move: board, state and move_cnt are unchanged. illegal pulses, illegal_code is updated and illegal_cnt increments (saturating).
- Both strobes in one cycle:
  - the turn-side move is evaluated normally
  - the non-turn strobe is always an out-of-turn violation
  - result: a single illegal pulse, code 11, one increment; the turn-side move is still committed if legal
- No strobe: no change.
- FULL is left only by reset or clear.
- Vector contents are ignored when the corresponding valid is low.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Latency is 1 cycle: a move sampled at edge k is visible on board/turn/move_cnt/full, and illegal/illegal_code/illegal_cnt, after edge k.
- illegal is high for exactly one cycle per rejecting cycle. Back-to-back rejections keep it high on consecutive cycles.
- Asynchronous reset asserts immediately, mid-move included: no partial commit. Deassertion must be synchronised externally.
- clear in the same cycle as a move: clear wins and the move is discarded silently (no illegal pulse, no count).
- One move per cycle maximum; throughput is 1 evaluation/cycle.

## Test plan
- Reset, then plyr_valid=1, plyr=9'b000010000 -> next cycle board[9:8]=01, turn=1, move_cnt=1, illegal=0.
- After the above, comp_valid=1, comp=9'b000010000 -> illegal pulse, illegal_code=01, illegal_cnt=1, board and turn unchanged. Then comp=9'b000000011 -> code 10, illegal_cnt=2.
- In P_TURN, comp_valid=1 and plyr_valid=1, plyr=9'b000000001 -> cell 0 = 01, turn=1, single illegal pulse, code 11, illegal_cnt incremented by 1.
- Nine alternating legal moves -> full=1, move_cnt=9 after the ninth. Any further strobe -> code 11, board unchanged. clear -> board 0, turn 0, full 0, illegal_cnt 0.
- CNT_W=2: five consecutive rejections -> illegal_cnt 1,2,3,3,3. Assert reset asynchronously between edges -> all outputs 0 before the next edge.
- SIZE=4: fill all 16 cells alternately -> full after the 16th move, move_cnt=16 (MC_W=5). clear and plyr_valid together -> no commit, no illegal pulse.
